insn_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the RV32 instruction decoder.
- Keeps the program counter and issues word-aligned reads to instruction memory over a valid/ready request channel.
- Buffers in-order responses in a small FIFO and presents {insn, pc} to decode with a valid/ready handshake.
- Handles redirects (branch/jump/trap target) by flushing buffered words and discarding responses still in flight.

---
 rtl/insn_fetch.sv | 143 ++++++++++++++
 tb/tb_insn_fetch.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/insn_fetch.sv
// RV32 instruction fetch: PC generation, credit-limited imem requests, in-order
// response buffering toward decode, and redirect flush with in-flight response drop.
module insn_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn,
  output logic [31:0] insn_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [0:0]    ST_START = 1'b0;
  localparam logic [0:0]    ST_RUN   = 1'b1;
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);
  localparam logic [CW:0]   CAP      = (CW + 1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [0:0]    state;
  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] count;
  logic [CW-1:0] drop_cnt;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] ifq_rd;
  logic [AW-1:0] ifq_wr;

  logic [31:0] buf_data [DEPTH];
  logic [31:0] buf_pc   [DEPTH];
  logic [31:0] ifq_pc   [DEPTH];

  logic        run;
  logic        accept;
  logic        discard;
  logic        push;
  logic        pop;
  logic [31:0] redirect_target;

  assign run             = (state == ST_RUN);
  // Dropped-but-unreturned requests keep their credit until the response shows up.
  assign imem_req_valid  = run && !redirect_valid &&
                           (({1'b0, outstanding} + {1'b0, count}) < CAP);
  assign imem_req_addr   = pc;
  assign accept          = imem_req_valid && imem_req_ready;
  assign discard         = imem_resp_valid && (redirect_valid || (drop_cnt != '0));
  assign push            = imem_resp_valid && !discard;
  assign insn_valid      = (count != '0);
  assign pop             = insn_valid && insn_ready;
  assign insn            = insn_valid ? buf_data[rd_ptr] : 32'h0;
  assign insn_pc         = insn_valid ? buf_pc[rd_ptr]   : 32'h0;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  always_comb begin
    outstanding_next = outstanding;
    if (accept && !imem_resp_valid) begin
      outstanding_next = outstanding + ONE;
    end else if (!accept && imem_resp_valid) begin
      outstanding_next = outstanding - ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_START;
      pc          <= RESET_PC;
      outstanding <= '0;
      count       <= '0;
      drop_cnt    <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      ifq_rd      <= '0;
      ifq_wr      <= '0;
    end else begin
      state       <= ST_RUN;
      outstanding <= outstanding_next;
      if (accept) begin
        ifq_wr <= ifq_wr + PTR_ONE;
      end
      if (imem_resp_valid) begin
        ifq_rd <= ifq_rd + PTR_ONE;
      end
      if (redirect_valid) begin
        // Everything still in flight after this cycle belongs to the old path.
        pc       <= redirect_target;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        drop_cnt <= outstanding_next;
      end else begin
        if (accept) begin
          pc <= pc + 32'd4;
        end
        if (discard) begin
          drop_cnt <= drop_cnt - ONE;
        end
        if (push) begin
          wr_ptr <= wr_ptr + PTR_ONE;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_ONE;
        end
        if (push && !pop) begin
          count <= count + ONE;
        end else if (pop && !push) begin
          count <= count - ONE;
        end
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by the pointers above.
  always_ff @(posedge clk) begin
    if (accept) begin
      ifq_pc[ifq_wr] <= pc;
    end
    if (push) begin
      buf_data[wr_ptr] <= imem_resp_data;
      buf_pc[wr_ptr]   <= ifq_pc[ifq_rd];
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_resp_valid && (count == FULL)));

  assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_resp_valid && (outstanding == '0)));

endmodule

// File: tb/tb_insn_fetch.sv
// Scoreboarded bench for insn_fetch: a memory model with random latency/ready,
// a stream-level PC/data reference, directed redirect cases and a PC-wrap instance.
module tb_insn_fetch;

  localparam logic [31:0] RST_PC  = 32'h0000_0000;
  localparam logic [31:0] WRAP_PC = 32'hFFFF_FFF8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        insn_valid, insn_ready;
  logic [31:0] insn, insn_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  logic        w_rst_n;
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_resp_valid;
  logic [31:0] w_resp_data;
  logic        w_insn_valid;
  logic [31:0] w_insn, w_insn_pc;
  logic        w_req_ready      = 1'b1;
  logic        w_insn_ready     = 1'b1;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc    = 32'h0;

  insn_fetch #(.RESET_PC(RST_PC), .DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(req_valid), .imem_req_ready(req_ready), .imem_req_addr(req_addr),
    .imem_resp_valid(resp_valid), .imem_resp_data(resp_data),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn(insn), .insn_pc(insn_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  insn_fetch #(.RESET_PC(WRAP_PC), .DEPTH(4)) dut_wrap (
    .clk(clk), .rst_n(w_rst_n),
    .imem_req_valid(w_req_valid), .imem_req_ready(w_req_ready), .imem_req_addr(w_req_addr),
    .imem_resp_valid(w_resp_valid), .imem_resp_data(w_resp_data),
    .insn_valid(w_insn_valid), .insn_ready(w_insn_ready), .insn(w_insn), .insn_pc(w_insn_pc),
    .redirect_valid(w_redirect_valid), .redirect_pc(w_redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
  } req_t;

  req_t        mem_q[$];
  logic [31:0] start_q[$];
  logic [31:0] acc_log[$];
  logic [31:0] dlv_log[$];
  int          cyc       = 0;
  int          lat_min   = 1;
  int          lat_max   = 1;
  int          ready_pct = 100;
  int          checks    = 0;
  int          errors    = 0;
  logic [31:0] exp_pc    = 32'h0;
  logic [31:0] first_after = 32'h0;
  bit          have_exp  = 1'b0;
  bit          await_first = 1'b0;
  bit          got_first = 1'b0;
  bit          w_done    = 1'b0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic reset_assert();
    rst_n      = 1'b0;
    resp_valid = 1'b0;
    mem_q.delete();
    start_q.delete();
    start_q.push_back(RST_PC);
    acc_log.delete();
    dlv_log.delete();
    #1;
  endtask

  task automatic reset_release();
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] raw, input logic [31:0] target);
    redirect_pc    = raw;
    redirect_valid = 1'b1;
    start_q.push_back(target);
    tick(1);
    redirect_valid = 1'b0;
  endtask

  task automatic expect_first(input string name, input logic [31:0] target);
    for (int i = 0; i < 60 && !got_first; i++) tick(1);
    chk(name, got_first ? first_after : 32'hDEAD_BEEF, target);
  endtask

  // Memory model: in-order responses, per-request latency, random request ready.
  initial begin
    resp_valid = 1'b0;
    resp_data  = 32'h0;
    req_ready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      req_ready  = ($urandom_range(99) < ready_pct);
      resp_valid = 1'b0;
      if (rst_n && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
        resp_valid = 1'b1;
        resp_data  = word_of(mem_q[0].addr);
        void'(mem_q.pop_front());
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && req_valid && req_ready) begin
        chk("req_align", {30'b0, req_addr[1:0]}, 32'h0);
        mem_q.push_back('{req_addr, cyc + int'($urandom_range(lat_max, lat_min))});
        acc_log.push_back(req_addr);
        chk("credit_limit", (mem_q.size() > 2) ? 32'h1 : 32'h0, 32'h0);
      end
    end
  end

  // Monitor: every instruction popped by decode must continue the current stream.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        have_exp = 1'b0;
      end else begin
        if (!have_exp && start_q.size() > 0) begin
          exp_pc   = start_q.pop_front();
          have_exp = 1'b1;
        end
        if (insn_valid && insn_ready) begin
          checks++;
          if (!have_exp || insn_pc !== exp_pc || insn !== word_of(exp_pc)) begin
            errors++;
            $display("FAIL deliver: got pc=0x%08h insn=0x%08h, expected pc=0x%08h insn=0x%08h",
                     insn_pc, insn, exp_pc, word_of(exp_pc));
          end
          dlv_log.push_back(insn_pc);
          if (await_first) begin
            first_after = insn_pc;
            got_first   = 1'b1;
            await_first = 1'b0;
          end
          exp_pc = exp_pc + 32'd4;
        end
        if (redirect_valid) begin
          if (start_q.size() > 0) exp_pc = start_q.pop_front();
          await_first = 1'b1;
          got_first   = 1'b0;
        end
      end
    end
  end

  // Wrap instance: DEPTH 4, always-ready memory with one-cycle latency.
  initial begin : wrap_bench
    logic [31:0] wacc[$];
    logic [31:0] wdlv[$];
    int          wacc_c[$];
    int          wdlv_c[$];
    logic        samp;
    logic [31:0] saddr;
    w_rst_n      = 1'b1;
    w_resp_valid = 1'b0;
    w_resp_data  = 32'h0;
    #1 w_rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2 w_rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      samp  = w_req_valid;
      saddr = w_req_addr;
      if (samp) begin
        wacc.push_back(saddr);
        wacc_c.push_back(k);
      end
      if (w_insn_valid) begin
        wdlv.push_back(w_insn_pc);
        wdlv_c.push_back(k);
        chk("wrap_data", w_insn, word_of(w_insn_pc));
      end
      @(posedge clk);
      #1;
      w_resp_valid = samp;
      w_resp_data  = word_of(saddr);
    end
    chk("wrap_req0", qget(wacc, 0), 32'hFFFF_FFF8);
    chk("wrap_req1", qget(wacc, 1), 32'hFFFF_FFFC);
    chk("wrap_req2", qget(wacc, 2), 32'h0000_0000);
    chk("wrap_req_back_to_back",
        (wacc_c.size() >= 3) ? 32'(wacc_c[2] - wacc_c[0]) : 32'hDEAD_BEEF, 32'd2);
    for (int i = 0; i < 6; i++) chk("wrap_dlv_pc", qget(wdlv, i), WRAP_PC + 32'(4 * i));
    chk("wrap_throughput",
        (wdlv_c.size() >= 6) ? 32'(wdlv_c[5] - wdlv_c[0]) : 32'hDEAD_BEEF, 32'd5);
    w_done = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish before 500000");
    $fatal(1);
  end

  initial begin
    bit          found;
    int          hits;
    int          n0;
    logic [31:0] raw;
    rst_n          = 1'b1;
    insn_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    start_q.push_back(RST_PC);
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_valid", 32'(req_valid), 32'h0);
    chk("rst_insn_valid", 32'(insn_valid), 32'h0);
    chk("rst_req_addr", req_addr, RST_PC);
    chk("rst_insn", insn, 32'h0);
    chk("rst_insn_pc", insn_pc, 32'h0);
    reset_release();

    // Basic streaming.
    insn_ready = 1'b1;
    tick(15);
    chk("req0", qget(acc_log, 0), 32'h0);
    chk("req1", qget(acc_log, 1), 32'h4);
    chk("req2", qget(acc_log, 2), 32'h8);
    chk("dlv0", qget(dlv_log, 0), 32'h0);
    chk("dlv1", qget(dlv_log, 1), 32'h4);
    chk("dlv2", qget(dlv_log, 2), 32'h8);

    // Async reset mid-stream, then decode stall against the credit limit.
    insn_ready = 1'b0;
    tick(3);
    chk("pre_reset_insn_valid", 32'(insn_valid), 32'h1);
    reset_assert();
    chk("async_rst_insn_valid", 32'(insn_valid), 32'h0);
    chk("async_rst_req_valid", 32'(req_valid), 32'h0);
    chk("async_rst_req_addr", req_addr, RST_PC);
    reset_release();
    tick(10);
    chk("stall_accepts", 32'(acc_log.size()), 32'd2);
    chk("stall_req_valid", 32'(req_valid), 32'h0);
    chk("stall_insn_valid", 32'(insn_valid), 32'h1);
    insn_ready = 1'b1;
    tick(10);
    chk("stall_dlv0", qget(dlv_log, 0), 32'h0);
    chk("stall_dlv1", qget(dlv_log, 1), 32'h4);
    chk("stall_dlv2", qget(dlv_log, 2), 32'h8);
    chk("stall_resume_req", qget(acc_log, 2), 32'h8);

    // Redirect with two requests in flight, memory latency 3.
    lat_min = 3;
    lat_max = 3;
    reset_assert();
    reset_release();
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (mem_q.size() == 2 && !resp_valid) found = 1'b1;
      else tick(1);
    end
    chk("two_inflight_reached", 32'(found), 32'h1);
    redirect(32'h0000_0100, 32'h0000_0100);
    expect_first("redirect_first_pc", 32'h0000_0100);
    tick(10);
    hits = 0;
    foreach (dlv_log[i]) if (dlv_log[i] == 32'h0 || dlv_log[i] == 32'h4) hits++;
    chk("no_stale_delivery", 32'(hits), 32'h0);
    chk("redirect_dlv0", qget(dlv_log, 0), 32'h0000_0100);

    // Redirect coinciding with a response and a pop.
    lat_min   = 1;
    lat_max   = 3;
    ready_pct = 70;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (resp_valid && insn_valid && insn_ready) found = 1'b1;
      else tick(1);
    end
    chk("resp_pop_coincide_reached", 32'(found), 32'h1);
    redirect(32'h0000_4000, 32'h0000_4000);
    expect_first("resp_pop_redirect_pc", 32'h0000_4000);

    // Redirect coinciding with a response while another request is in flight.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (resp_valid && mem_q.size() >= 1) found = 1'b1;
      else tick(1);
    end
    chk("resp_inflight_coincide_reached", 32'(found), 32'h1);
    redirect(32'h0000_8000, 32'h0000_8000);
    expect_first("resp_inflight_redirect_pc", 32'h0000_8000);

    redirect(32'h0000_0203, 32'h0000_0200);
    expect_first("redirect_lsb_ignored", 32'h0000_0200);

    redirect(32'h0000_0300, 32'h0000_0300);
    redirect(32'h0000_0402, 32'h0000_0400);
    expect_first("back_to_back_redirect", 32'h0000_0400);

    // Random traffic: decode stalls, memory stalls, redirects anywhere.
    lat_max = 4;
    n0 = dlv_log.size();
    for (int i = 0; i < 500; i++) begin
      insn_ready = ($urandom_range(99) < 70);
      if ($urandom_range(99) < 4) begin
        raw            = $urandom;
        redirect_pc    = raw;
        redirect_valid = 1'b1;
        start_q.push_back(raw & 32'hFFFF_FFFC);
      end else begin
        redirect_valid = 1'b0;
      end
      tick(1);
    end
    redirect_valid = 1'b0;
    insn_ready     = 1'b1;
    tick(30);
    chk("stress_progress", (dlv_log.size() > n0 + 50) ? 32'h1 : 32'h0, 32'h1);

    for (int i = 0; i < 100 && !w_done; i++) tick(1);
    chk("wrap_bench_done", 32'(w_done), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
